// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly in
// front of the IF/ID latch. Owns the PC, runs a request/acknowledge
// instruction-memory port with at most one transaction outstanding, and
// presents {npc, instr, instr_valid} to IF/ID. A two-entry buffer (output
// slot + one skid entry) absorbs the fetch that is already in flight when
// IF/ID stalls. Taken branches from MEM (pcsrc) flush everything buffered and
// steer the next fetch to branch_target; a fetch still in flight at that point
// is allowed to complete and its data is dropped.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   stall          IF/ID cannot accept the output slot this cycle
//   pcsrc          taken branch/jump redirect (pulse or level)
//   branch_target  redirect PC, sampled when pcsrc=1
//   imem_req       fetch request, held until imem_ack
//   imem_addr      fetch address (always the PC)
//   imem_ack       response valid, ends the transaction
//   imem_rdata     instruction word, valid with imem_ack
//   npc            PC+PC_INC of the delivered instruction
//   instr          delivered instruction, NOP_INSTR when not valid
//   instr_valid    npc/instr hold a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] npc,
    output logic [31:0] instr,
    output logic        instr_valid
);

    // IDLE    : one cycle after reset before the first request
    // FETCH   : request outstanding for pc, data is wanted
    // DISCARD : request outstanding for a wrong-path pc, data will be dropped
    // HOLD    : output slot and skid both full, no request
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_npc_q, skid_npc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic [31:0] pc_next;
    logic        slot_free;

    assign pc_next   = pc_q + PC_INC;
    // The slot can take new data at this edge if it is empty or being consumed.
    assign slot_free = ~valid_q | ~stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = redirect_q;
        npc_d        = npc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        skid_npc_d   = skid_npc_q;
        skid_instr_d = skid_instr_q;

        // Consumed slot empties unless something below refills it; npc is kept.
        if (valid_q && !stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (imem_ack) begin
                    if (pcsrc) begin
                        // Fetched word is wrong-path; restart at the target.
                        pc_d = branch_target;
                    end else if (slot_free) begin
                        instr_d = imem_rdata;
                        npc_d   = pc_next;
                        valid_d = 1'b1;
                        pc_d    = pc_next;
                    end else begin
                        skid_npc_d   = pc_next;
                        skid_instr_d = imem_rdata;
                        pc_d         = pc_next;
                        state_d      = HOLD;
                    end
                end else if (pcsrc) begin
                    // Cannot abandon the bus transaction; remember where to go.
                    redirect_d = branch_target;
                    state_d    = DISCARD;
                end
            end

            DISCARD: begin
                if (pcsrc) begin
                    redirect_d = branch_target;
                end
                if (imem_ack) begin
                    pc_d    = pcsrc ? branch_target : redirect_q;
                    state_d = FETCH;
                end
            end

            HOLD: begin
                if (pcsrc) begin
                    pc_d    = branch_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    npc_d   = skid_npc_q;
                    instr_d = skid_instr_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect kills whatever is presented, stalled or not.
        if (pcsrc && (state_q != IDLE)) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            redirect_q   <= 32'h0;
            npc_q        <= 32'h0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
            skid_npc_q   <= 32'h0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            npc_q        <= npc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            skid_npc_q   <= skid_npc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_addr   = pc_q;
    assign npc         = npc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Reference model: the stage is an ordered queue of at most two delivered
// instructions plus a PC and a "drop the next response" flag. Expected outputs
// are derived from that queue every cycle. Memory responds with
// rdata = addr ^ 32'hA5A5A5A5 after a configurable latency.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, pcsrc, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, npc, instr;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .npc           (npc),
        .instr         (instr),
        .instr_valid   (instr_valid)
    );

    // Second instance for the PC wrap-around case.
    logic        w_rst, w_ack, w_req, w_valid;
    logic [31:0] w_rdata, w_addr, w_npc, w_instr;

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk           (clk),
        .rst           (w_rst),
        .stall         (1'b0),
        .pcsrc         (1'b0),
        .branch_target (32'h0),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (w_ack),
        .imem_rdata    (w_rdata),
        .npc           (w_npc),
        .instr         (w_instr),
        .instr_valid   (w_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] instr;
    } item_t;

    item_t       mq[$];
    logic [31:0] m_pc, m_npc, m_redirect;
    bit          m_started, m_discard;

    task automatic model_reset();
        mq.delete();
        m_pc       = 32'h0;
        m_npc      = 32'h0;
        m_redirect = 32'h0;
        m_started  = 1'b0;
        m_discard  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        item_t it;
        bit    req;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_started) begin
            m_started = 1'b1;
            return;
        end
        req = (mq.size() < 2);
        if (pcsrc) begin
            mq.delete();
            if (req && imem_ack) begin
                m_pc      = branch_target;
                m_discard = 1'b0;
            end else if (req) begin
                m_discard  = 1'b1;
                m_redirect = branch_target;
            end else begin
                m_pc = branch_target;
            end
        end else begin
            if (mq.size() > 0 && !stall) void'(mq.pop_front());
            if (req && imem_ack) begin
                if (m_discard) begin
                    m_pc      = m_redirect;
                    m_discard = 1'b0;
                end else begin
                    it.npc   = m_pc + 32'd4;
                    it.instr = imem_rdata;
                    mq.push_back(it);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        if (mq.size() > 0) m_npc = mq[0].npc;
    endtask

    task automatic compare();
        logic [31:0] e_instr;
        bit          e_req;
        e_instr = (mq.size() > 0) ? mq[0].instr : 32'h0;
        e_req   = m_started && (mq.size() < 2);
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        chk("instr", instr, e_instr);
        chk("npc", npc, m_npc);
    endtask

    // ---------------- memory responder ----------------
    bit in_txn    = 1'b0;
    bit spur_ack  = 1'b0;
    int cnt       = 0;
    int lat_min   = 1;
    int lat_max   = 1;

    task automatic mem_drive();
        if (rst) begin
            in_txn   = 1'b0;
            imem_ack = 1'b0;
        end else if (spur_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
        end else begin
            imem_ack = 1'b0;
            if (imem_req && !in_txn) begin
                in_txn = 1'b1;
                cnt    = $urandom_range(lat_max, lat_min);
            end else if (in_txn) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ 32'hA5A5_A5A5;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge after checking outputs.
    task automatic tick();
        mem_drive();
        model_step();
        @(posedge clk);
        if (imem_ack) in_txn = 1'b0;
        @(negedge clk);
        compare();
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3, 0))
            0:       return {$urandom_range(32'h3FFF, 0), 2'b00};
            1:       return 32'hFFFF_FFF8;
            2:       return $urandom;
            default: return 32'h0000_0040;
        endcase
    endfunction

    bit found;

    initial begin
        rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; branch_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        w_rst = 1'b1; w_ack = 1'b0; w_rdata = 32'h0;
        model_reset();

        tick();
        tick();
        chk("reset_req", 32'(imem_req), 32'h0);
        chk("reset_valid", 32'(instr_valid), 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_npc", npc, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);

        // Sequential fetch, ack one cycle after each request.
        rst = 1'b0;
        tick();
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        tick();
        chk("no_data_yet", 32'(instr_valid), 32'h0);
        tick();
        chk("first_valid", 32'(instr_valid), 32'h1);
        chk("first_npc", npc, 32'h4);
        chk("first_instr", instr, 32'hA5A5_A5A5);
        chk("second_addr", imem_addr, 32'h4);

        // Stall: the in-flight fetch lands in the skid, then requests stop.
        stall = 1'b1;
        repeat (5) tick();
        chk("hold_req", 32'(imem_req), 32'h0);
        chk("hold_npc", npc, 32'h4);
        chk("hold_valid", 32'(instr_valid), 32'h1);
        stall = 1'b0;
        tick();
        chk("skid_npc", npc, 32'h8);
        chk("skid_instr", instr, 32'hA5A5_A5A1);
        chk("skid_addr", imem_addr, 32'h8);

        // Redirect while the request to 0x8 is outstanding (3-cycle ack).
        lat_min = 3; lat_max = 3;
        tick();
        pcsrc = 1'b1; branch_target = 32'h100;
        tick();
        chk("flush_valid", 32'(instr_valid), 32'h0);
        chk("flush_instr", instr, 32'h0);
        chk("flush_addr_held", imem_addr, 32'h8);
        pcsrc = 1'b0; lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (instr_valid) found = 1'b1;
        end
        chk("branch_timeout", 32'(found), 32'h1);
        chk("branch_npc", npc, 32'h104);
        chk("branch_instr", instr, 32'hA5A5_A4A5);

        // pcsrc coincident with imem_ack.
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (imem_req && in_txn && cnt == 1) found = 1'b1;
        end
        chk("coinc_timeout", 32'(found), 32'h1);
        pcsrc = 1'b1; branch_target = 32'h200;
        tick();
        chk("coinc_valid", 32'(instr_valid), 32'h0);
        chk("coinc_addr", imem_addr, 32'h200);
        pcsrc = 1'b0;

        // pcsrc in HOLD with stall held.
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (!imem_req) found = 1'b1;
        end
        chk("hold2_timeout", 32'(found), 32'h1);
        pcsrc = 1'b1; branch_target = 32'h300;
        tick();
        chk("holdflush_valid", 32'(instr_valid), 32'h0);
        chk("holdflush_instr", instr, 32'h0);
        chk("holdflush_addr", imem_addr, 32'h300);
        chk("holdflush_req", 32'(imem_req), 32'h1);
        pcsrc = 1'b0; stall = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            stall         = ($urandom_range(99, 0) < 30);
            pcsrc         = ($urandom_range(99, 0) < 7);
            branch_target = pick_target();
            rst           = ($urandom_range(499, 0) == 0);
            lat_min       = 1;
            lat_max       = ($urandom_range(3, 0) == 0) ? 4 : 1;
            tick();
        end
        rst = 1'b0; stall = 1'b0; pcsrc = 1'b0;

        // Reset while in DISCARD, then a late ack while IDLE.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req && in_txn && cnt >= 2) found = 1'b1;
        end
        chk("discard_timeout", 32'(found), 32'h1);
        pcsrc = 1'b1; branch_target = 32'h80;
        tick();
        pcsrc = 1'b0; rst = 1'b1;
        tick();
        chk("rst_disc_req", 32'(imem_req), 32'h0);
        chk("rst_disc_addr", imem_addr, 32'h0);
        chk("rst_disc_valid", 32'(instr_valid), 32'h0);
        rst = 1'b0; spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        chk("late_ack_req", 32'(imem_req), 32'h1);
        chk("late_ack_addr", imem_addr, 32'h0);
        chk("late_ack_valid", 32'(instr_valid), 32'h0);
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 500; i++) begin
            stall         = ($urandom_range(99, 0) < 40);
            pcsrc         = ($urandom_range(99, 0) < 5);
            branch_target = pick_target();
            tick();
        end

        // PC wrap: RESET_PC = 0xFFFFFFFC.
        rst = 1'b1;
        chk("wrap_reset_req", 32'(w_req), 32'h0);
        chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
        w_rst = 1'b0;
        @(negedge clk);
        chk("wrap_first_req", 32'(w_req), 32'h1);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        w_ack = 1'b1; w_rdata = 32'h1234_5678;
        @(negedge clk);
        w_ack = 1'b0;
        chk("wrap_valid", 32'(w_valid), 32'h1);
        chk("wrap_npc", w_npc, 32'h0);
        chk("wrap_instr", w_instr, 32'h1234_5678);
        chk("wrap_next_addr", w_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
